dm_port_arbiter: RTL

DM_PORT_ARBITER -- requirements
Module: dm_port_arbiter

---
 rtl/dm_port_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: CPU / DMA arbiter in front of one single-port data memory.
// Latency: grant and mem_* drive are combinational; read data returns 1 cycle after the grant.
// Backpressure: a denied CPU request raises stall_cpu; a denied DMA request is simply not granted (nothing is queued).
//
// Optional feature macro: DM_ARB_STARVE_GUARD_EN
//   defined   -> after STARVE_LIMIT consecutive denied DMA cycles the DMA port is forced
//                through for one cycle, overriding the CPU.
//   undefined -> strict CPU priority; DMA may wait indefinitely.
//
// Ports
//   clk, reset                      clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata           CPU (pipeline MEM stage) request
//   cpu_gnt, stall_cpu              CPU accepted this cycle / pipeline must hold
//   cpu_rvalid, cpu_rdata           CPU read return (one cycle after a granted read)
//   dma_req/we/addr/wdata           loader/debug port request
//   dma_gnt, dma_rvalid, dma_rdata  loader/debug grant and read return
//   mem_en/we/addr/wdata, mem_rdata data memory interface
//   cpu_grant_cnt, dma_grant_cnt    free-running 16-bit grant counters
module dm_port_arbiter #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  // CPU port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              stall_cpu,
  // DMA / loader port
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  // Data memory
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // Performance counters
  output logic [15:0]       cpu_grant_cnt,
  output logic [15:0]       dma_grant_cnt
);

  // The starvation counter is 4 bits wide, so the limit must fit in 1..15.
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
    $error("dm_port_arbiter: STARVE_LIMIT must be in 1..15");
  end

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic force_dma;
  logic cpu_gnt_w;
  logic dma_gnt_w;

  // Reset gates every combinational output so they drop the instant reset
  // rises, not at the next clock edge.
  assign cpu_gnt_w = ~reset & cpu_req & ~force_dma;
  assign dma_gnt_w = ~reset & dma_req & ~cpu_gnt_w;

  assign cpu_gnt   = cpu_gnt_w;
  assign dma_gnt   = dma_gnt_w;
  assign stall_cpu = ~reset & cpu_req & ~cpu_gnt_w;

`ifdef DM_ARB_STARVE_GUARD_EN
  // ---------------------------------------------------------------------------
  // Starvation guard: counts consecutive cycles in which DMA asked and lost.
  // Saturates at the limit; the limit value itself forces the next DMA grant,
  // and that grant clears the count so the CPU gets the following cycles.
  // ---------------------------------------------------------------------------
  localparam logic [3:0] STARVE_LIM4 = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_q;
  logic [3:0] starve_cnt_d;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!dma_req || dma_gnt_w) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q < STARVE_LIM4) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_q <= 4'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign force_dma = dma_req & (starve_cnt_q == STARVE_LIM4);
`else
  // Strict CPU priority: the DMA port only wins on cycles the CPU is idle.
  assign force_dma = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Memory request mux: the winner drives the memory; idle cycles drive zeros.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt_w) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_gnt_w) begin
      mem_en    = 1'b1;
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Read return routing. The memory answers exactly one cycle after an enabled
  // read, so a single pending bit per requester is enough to steer mem_rdata.
  // Only one port is granted per cycle, so at most one pending bit is set.
  // ---------------------------------------------------------------------------
  logic cpu_pend_q;
  logic cpu_pend_d;
  logic dma_pend_q;
  logic dma_pend_d;

  assign cpu_pend_d = cpu_gnt_w & ~cpu_we;
  assign dma_pend_d = dma_gnt_w & ~dma_we;

  // Async clear also drops a read granted just before reset, so it never
  // surfaces as an rvalid once reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_pend_q <= 1'b0;
      dma_pend_q <= 1'b0;
    end else begin
      cpu_pend_q <= cpu_pend_d;
      dma_pend_q <= dma_pend_d;
    end
  end

  assign cpu_rvalid = cpu_pend_q;
  assign dma_rvalid = dma_pend_q;
  assign cpu_rdata  = cpu_pend_q ? mem_rdata : '0;
  assign dma_rdata  = dma_pend_q ? mem_rdata : '0;

  // ---------------------------------------------------------------------------
  // Grant counters, wrapping naturally at 16 bits.
  // ---------------------------------------------------------------------------
  logic [15:0] cpu_cnt_q;
  logic [15:0] cpu_cnt_d;
  logic [15:0] dma_cnt_q;
  logic [15:0] dma_cnt_d;

  assign cpu_cnt_d = cpu_cnt_q + {15'd0, cpu_gnt_w};
  assign dma_cnt_d = dma_cnt_q + {15'd0, dma_gnt_w};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_cnt_q <= 16'd0;
      dma_cnt_q <= 16'd0;
    end else begin
      cpu_cnt_q <= cpu_cnt_d;
      dma_cnt_q <= dma_cnt_d;
    end
  end

  assign cpu_grant_cnt = cpu_cnt_q;
  assign dma_grant_cnt = dma_cnt_q;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_one_grant : assert property (@(posedge clk) disable iff (reset)
    !(cpu_gnt_w && dma_gnt_w));
  a_one_rvalid : assert property (@(posedge clk) disable iff (reset)
    !(cpu_pend_q && dma_pend_q));
`endif

endmodule
